fabric_crossbar_scheduler: RTL and testbench

Parametrised packet-level scheduler for the fabric crossbar. It replaces the fixed 28-in/8-out hard-coded link selection with generic per-output round-robin arbitration. Each source requests one crossbar output (unicast) or all outputs (broadcast, replayed once per output). The scheduler issues locked grants that last until end-of-packet, and reports when a source's packet has been delivered everywhere so the source FIFO may pop it.

---
 rtl/fabric_crossbar_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_fabric_crossbar_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_crossbar_scheduler.sv
// Packet-level scheduler for the fabric crossbar.
// Each output runs its own round-robin arbiter over the sources. A grant stays
// locked until end-of-packet or until the watchdog expires. A source can hold
// only one lock at a time, so broadcast packets are replayed on one output
// after another. src_complete fires once the packet has reached every target.
//
// Per-output state:
// state  | meaning
// IDLE   | output free; arbitrates among eligible sources while dst_ready
// LOCKED | output forwards lock_src until eop or watchdog release
module fabric_crossbar_scheduler #(
    parameter int  NUM_SRC        = 28,
    parameter int  NUM_DST        = 8,
    parameter int  TIMEOUT_CYCLES = 4096,
    localparam int SRC_BITS       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int DST_BITS       = (NUM_DST > 1) ? $clog2(NUM_DST) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           src_req,
    input  logic [NUM_SRC-1:0]           src_broadcast,
    input  logic [NUM_SRC*DST_BITS-1:0]  src_dst,
    input  logic [NUM_SRC-1:0]           src_eop,
    input  logic [NUM_DST-1:0]           dst_ready,
    output logic [NUM_SRC-1:0]           src_grant,
    output logic [NUM_SRC-1:0]           src_complete,
    output logic [NUM_DST-1:0]           dst_grant_valid,
    output logic [NUM_DST*SRC_BITS-1:0]  dst_grant_src,
    output logic [NUM_DST-1:0]           dst_timeout
);

    localparam int WD_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_BITS-1:0] WD_LAST =
        (TIMEOUT_CYCLES > 0) ? WD_BITS'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} dst_state_t;

    dst_state_t          state [NUM_DST];
    dst_state_t          state_next [NUM_DST];
    logic [SRC_BITS-1:0] lock_src [NUM_DST];
    logic [SRC_BITS-1:0] rr_ptr [NUM_DST];
    logic [WD_BITS-1:0]  wd_cnt [NUM_DST];
    logic [NUM_DST-1:0]  pending [NUM_SRC];
    logic [NUM_DST-1:0]  pend_next [NUM_SRC];
    logic [NUM_SRC-1:0]  active;
    logic [NUM_SRC-1:0]  complete_q;
    logic [NUM_DST-1:0]  timeout_q;

    logic [NUM_SRC-1:0]  src_locked;
    logic [NUM_SRC-1:0]  accept;
    logic [NUM_SRC-1:0]  cpl_next;
    logic [NUM_DST-1:0]  release_d;
    logic [NUM_DST-1:0]  timeout_d;
    logic [NUM_DST-1:0]  gnt_valid;
    logic [SRC_BITS-1:0] gnt_src [NUM_DST];

    // Lock bookkeeping: which sources are locked and which outputs release now.
    always_comb begin
        src_locked = '0;
        release_d  = '0;
        timeout_d  = '0;
        for (int d = 0; d < NUM_DST; d++) begin
            if (state[d] == LOCKED) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (lock_src[d] == SRC_BITS'(s)) begin
                        src_locked[s] = 1'b1;
                    end
                end
                // An eop in the expiry cycle counts as a normal release.
                if (src_eop[lock_src[d]]) begin
                    release_d[d] = 1'b1;
                end else if ((TIMEOUT_CYCLES > 0) && (wd_cnt[d] == WD_LAST)) begin
                    release_d[d] = 1'b1;
                    timeout_d[d] = 1'b1;
                end
            end
        end
    end

    // Round-robin arbitration. Outputs are visited lowest index first, and
    // each grant marks its source taken so a higher output cannot also win it.
    always_comb begin
        logic [NUM_SRC-1:0] taken;
        int                 idx;
        taken     = src_locked;
        idx       = 0;
        gnt_valid = '0;
        for (int d = 0; d < NUM_DST; d++) begin
            gnt_src[d]    = '0;
            state_next[d] = state[d];
            if (state[d] == IDLE && dst_ready[d]) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    idx = int'(rr_ptr[d]) + k;
                    if (idx >= NUM_SRC) begin
                        idx = idx - NUM_SRC;
                    end
                    if (!gnt_valid[d] && pending[idx][d] && !taken[idx]) begin
                        gnt_valid[d] = 1'b1;
                        gnt_src[d]   = SRC_BITS'(idx);
                        taken[idx]   = 1'b1;
                    end
                end
                if (gnt_valid[d]) begin
                    state_next[d] = LOCKED;
                end
            end else if (release_d[d]) begin
                state_next[d] = IDLE;
            end
        end
    end

    // Per-source acceptance, pending-mask clearing and completion detection.
    always_comb begin
        logic [NUM_DST-1:0] rel_mask;
        rel_mask = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            rel_mask = '0;
            for (int d = 0; d < NUM_DST; d++) begin
                if (release_d[d] && lock_src[d] == SRC_BITS'(s)) begin
                    rel_mask[d] = 1'b1;
                end
            end
            pend_next[s] = pending[s] & ~rel_mask;
            cpl_next[s]  = active[s] && (|rel_mask) && (pend_next[s] == '0);
            accept[s]    = src_req[s] && !active[s] &&
                           (src_broadcast[s] ||
                            (int'(src_dst[s*DST_BITS +: DST_BITS]) < NUM_DST));
        end
    end

    // Source state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            active     <= '0;
            complete_q <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                pending[s] <= '0;
            end
        end else begin
            complete_q <= cpl_next;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (accept[s]) begin
                    active[s]  <= 1'b1;
                    pending[s] <= src_broadcast[s] ? {NUM_DST{1'b1}} :
                                  (NUM_DST'(1) << src_dst[s*DST_BITS +: DST_BITS]);
                end else if (active[s]) begin
                    pending[s] <= pend_next[s];
                    if (cpl_next[s]) begin
                        active[s] <= 1'b0;
                    end
                end
            end
        end
    end

    // Output state registers: lock, round-robin pointer and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= '0;
            for (int d = 0; d < NUM_DST; d++) begin
                state[d]    <= IDLE;
                lock_src[d] <= '0;
                rr_ptr[d]   <= '0;
                wd_cnt[d]   <= '0;
            end
        end else begin
            timeout_q <= timeout_d;
            for (int d = 0; d < NUM_DST; d++) begin
                state[d] <= state_next[d];
                if (release_d[d]) begin
                    rr_ptr[d] <= (lock_src[d] == SRC_BITS'(NUM_SRC - 1)) ?
                                 '0 : lock_src[d] + 1'b1;
                end else if (gnt_valid[d]) begin
                    lock_src[d] <= gnt_src[d];
                    wd_cnt[d]   <= '0;
                end else if (state[d] == LOCKED && TIMEOUT_CYCLES > 0) begin
                    wd_cnt[d] <= wd_cnt[d] + 1'b1;
                end
            end
        end
    end

    // Output mapping from registered state.
    always_comb begin
        src_grant     = src_locked;
        src_complete  = complete_q;
        dst_timeout   = timeout_q;
        dst_grant_src = '0;
        for (int d = 0; d < NUM_DST; d++) begin
            dst_grant_valid[d] = (state[d] == LOCKED);
            dst_grant_src[d*SRC_BITS +: SRC_BITS] =
                (state[d] == LOCKED) ? lock_src[d] : '0;
        end
    end

endmodule

// File: tb/tb_fabric_crossbar_scheduler.sv
// Scoreboard bench for fabric_crossbar_scheduler: stimulus pushes expected
// events (grant, drop, timeout, complete) with their cycle; the monitor pops
// and compares whenever the DUT shows such an event.
module tb_fabric_crossbar_scheduler;

    localparam int NS = 28;
    localparam int ND = 8;
    localparam int SB = 5;
    localparam int DB = 3;
    localparam int K_GNT = 0, K_DROP = 1, K_TMO = 2, K_CPL = 3;

    typedef struct {
        int kind;
        int idx;
        int val;
        int cyc;
    } ev_t;

    logic              clk = 0;
    logic              rst = 1;
    logic [NS-1:0]     src_req = '0;
    logic [NS-1:0]     src_broadcast = '0;
    logic [NS*DB-1:0]  src_dst = '0;
    logic [NS-1:0]     src_eop = '0;
    logic [ND-1:0]     dst_ready = '1;
    logic [NS-1:0]     src_grant;
    logic [NS-1:0]     src_complete;
    logic [ND-1:0]     dst_grant_valid;
    logic [ND*SB-1:0]  dst_grant_src;
    logic [ND-1:0]     dst_timeout;

    ev_t          exp_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           passes = 0;
    bit           mon_en = 0;
    bit           chk_zero = 0;
    bit           bc_phase = 0;
    bit           done = 0;
    logic [ND-1:0] prev_gv = '0;
    int           t0;

    fabric_crossbar_scheduler #(
        .NUM_SRC(NS), .NUM_DST(ND), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .src_req(src_req), .src_broadcast(src_broadcast), .src_dst(src_dst),
        .src_eop(src_eop), .dst_ready(dst_ready),
        .src_grant(src_grant), .src_complete(src_complete),
        .dst_grant_valid(dst_grant_valid), .dst_grant_src(dst_grant_src),
        .dst_timeout(dst_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_GNT:  return "grant";
            K_DROP: return "drop";
            K_TMO:  return "timeout";
            default: return "complete";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int idx, input int val, input int c);
        ev_t e;
        e.kind = kind; e.idx = idx; e.val = val; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int kind, input int idx, input int val);
        int found;
        found = -1;
        foreach (exp_q[i]) begin
            if (found < 0 && exp_q[i].kind == kind && exp_q[i].idx == idx &&
                exp_q[i].cyc == cyc) found = i;
        end
        checks++;
        if (found < 0) begin
            $display("FAIL %s[%0d] cycle %0d: got unexpected event (val %0d), required none",
                     kname(kind), idx, cyc, val);
        end else begin
            if (exp_q[found].val == val) passes++;
            else $display("FAIL %s[%0d] cycle %0d: got val %0d, required %0d",
                          kname(kind), idx, cyc, val, exp_q[found].val);
            exp_q.delete(found);
        end
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc, act, req);
    endtask

    // Monitor: compares DUT events against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < ND; d++) begin
                if (dst_grant_valid[d] && !prev_gv[d]) begin
                    match_ev(K_GNT, d, int'(dst_grant_src[d*SB +: SB]));
                    chk($sformatf("src_grant[%0d]", dst_grant_src[d*SB +: SB]),
                        longint'(src_grant[dst_grant_src[d*SB +: SB]]), 1);
                end
                if (!dst_grant_valid[d] && prev_gv[d]) match_ev(K_DROP, d, 0);
                if (dst_timeout[d]) match_ev(K_TMO, d, 0);
            end
            for (int s = 0; s < NS; s++) begin
                if (src_complete[s]) match_ev(K_CPL, s, 0);
            end
            if (bc_phase) chk("one_lock_at_a_time", longint'($countones(dst_grant_valid) <= 1), 1);
            if (chk_zero) begin
                chk("zero_dst_grant_valid", longint'(dst_grant_valid), 0);
                chk("zero_dst_grant_src", longint'(dst_grant_src), 0);
                chk("zero_src_grant", longint'(src_grant), 0);
                chk("zero_src_complete", longint'(src_complete), 0);
                chk("zero_dst_timeout", longint'(dst_timeout), 0);
            end
        end
        prev_gv <= dst_grant_valid;
        if (done) begin
            foreach (exp_q[i]) begin
                checks++;
                $display("FAIL missing %s[%0d] at cycle %0d: got nothing, required val %0d",
                         kname(exp_q[i].kind), exp_q[i].idx, exp_q[i].cyc, exp_q[i].val);
            end
            $display("%0d/%0d checks passed", passes, checks);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no end of run, required finish");
        $fatal(1);
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int s, input bit bc, input int d);
        src_req[s] = 1'b1;
        src_broadcast[s] = bc;
        src_dst[s*DB +: DB] = 3'(d);
    endtask

    task automatic clear_req();
        src_req = '0;
        src_broadcast = '0;
    endtask

    task automatic eop_at(input int s, input int c);
        wait_until(c);
        src_eop[s] = 1'b1;
        wait_until(c + 1);
        src_eop[s] = 1'b0;
    endtask

    initial begin
        // Reset state
        wait_until(3);
        rst = 0;
        mon_en = 1;
        chk_zero = 1;
        wait_until(4);
        chk_zero = 0;

        // Unicast: src 3 -> dst 5
        t0 = cyc + 1;
        expect_ev(K_GNT, 5, 3, t0 + 2);
        expect_ev(K_DROP, 5, 0, t0 + 11);
        expect_ev(K_CPL, 3, 0, t0 + 11);
        wait_until(t0);
        set_req(3, 0, 5);
        wait_until(t0 + 1);
        clear_req();
        eop_at(3, t0 + 10);
        wait_until(t0 + 14);

        // Round robin on dst 2 with pointer wrap
        t0 = cyc + 1;
        expect_ev(K_GNT, 2, 0, t0 + 2);
        expect_ev(K_DROP, 2, 0, t0 + 8);  expect_ev(K_CPL, 0, 0, t0 + 8);
        expect_ev(K_GNT, 2, 4, t0 + 9);
        expect_ev(K_DROP, 2, 0, t0 + 15); expect_ev(K_CPL, 4, 0, t0 + 15);
        expect_ev(K_GNT, 2, 27, t0 + 16);
        expect_ev(K_DROP, 2, 0, t0 + 22); expect_ev(K_CPL, 27, 0, t0 + 22);
        expect_ev(K_GNT, 2, 0, t0 + 23);
        expect_ev(K_DROP, 2, 0, t0 + 26); expect_ev(K_CPL, 0, 0, t0 + 26);
        expect_ev(K_GNT, 2, 4, t0 + 27);
        expect_ev(K_DROP, 2, 0, t0 + 31); expect_ev(K_CPL, 4, 0, t0 + 31);
        wait_until(t0);
        set_req(0, 0, 2); set_req(4, 0, 2); set_req(27, 0, 2);
        wait_until(t0 + 1);
        clear_req();
        eop_at(0, t0 + 7);
        eop_at(4, t0 + 14);
        wait_until(t0 + 18);
        set_req(0, 0, 2); set_req(4, 0, 2);
        wait_until(t0 + 19);
        clear_req();
        eop_at(27, t0 + 21);
        eop_at(0, t0 + 25);
        eop_at(4, t0 + 30);
        wait_until(t0 + 34);

        // Broadcast from src 7: serial grants on dst 0..7, one completion
        t0 = cyc + 1;
        for (int k = 0; k < ND; k++) begin
            expect_ev(K_GNT, k, 7, t0 + 2 + 5*k);
            expect_ev(K_DROP, k, 0, t0 + 6 + 5*k);
        end
        expect_ev(K_CPL, 7, 0, t0 + 41);
        bc_phase = 1;
        wait_until(t0);
        set_req(7, 1, 0);
        wait_until(t0 + 1);
        clear_req();
        for (int k = 0; k < ND; k++) eop_at(7, t0 + 5 + 5*k);
        wait_until(t0 + 44);
        bc_phase = 0;

        // Same-cycle conflict: src 1 broadcast, src 2 unicast dst 3
        t0 = cyc + 1;
        expect_ev(K_GNT, 0, 1, t0 + 2);
        expect_ev(K_GNT, 3, 2, t0 + 2);
        expect_ev(K_DROP, 3, 0, t0 + 5); expect_ev(K_CPL, 2, 0, t0 + 5);
        expect_ev(K_DROP, 0, 0, t0 + 7);
        for (int k = 1; k < ND; k++) begin
            expect_ev(K_GNT, k, 1, t0 + 8 + 3*(k-1));
            expect_ev(K_DROP, k, 0, t0 + 10 + 3*(k-1));
        end
        expect_ev(K_CPL, 1, 0, t0 + 28);
        wait_until(t0);
        set_req(1, 1, 0); set_req(2, 0, 3);
        wait_until(t0 + 1);
        clear_req();
        eop_at(2, t0 + 4);
        eop_at(1, t0 + 6);
        for (int k = 1; k < ND; k++) eop_at(1, t0 + 9 + 3*(k-1));
        wait_until(t0 + 31);

        // Watchdog: dst 6 times out, dst 4 eop lands on the expiry cycle
        t0 = cyc + 1;
        expect_ev(K_GNT, 4, 11, t0 + 2);
        expect_ev(K_GNT, 6, 10, t0 + 2);
        expect_ev(K_DROP, 4, 0, t0 + 18); expect_ev(K_CPL, 11, 0, t0 + 18);
        expect_ev(K_DROP, 6, 0, t0 + 18); expect_ev(K_TMO, 6, 0, t0 + 18);
        expect_ev(K_CPL, 10, 0, t0 + 18);
        wait_until(t0);
        set_req(10, 0, 6); set_req(11, 0, 4);
        wait_until(t0 + 1);
        clear_req();
        eop_at(11, t0 + 17);
        wait_until(t0 + 21);

        // dst_ready low holds off a new grant
        t0 = cyc + 1;
        expect_ev(K_GNT, 0, 9, t0 + 6);
        expect_ev(K_DROP, 0, 0, t0 + 8); expect_ev(K_CPL, 9, 0, t0 + 8);
        wait_until(t0);
        dst_ready[0] = 1'b0;
        set_req(9, 0, 0);
        wait_until(t0 + 1);
        clear_req();
        wait_until(t0 + 5);
        dst_ready[0] = 1'b1;
        eop_at(9, t0 + 7);
        wait_until(t0 + 11);

        // Reset mid-broadcast, then fresh arbitration from rr_ptr 0
        t0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            expect_ev(K_GNT, k, 5, t0 + 2 + 3*k);
            expect_ev(K_DROP, k, 0, t0 + 4 + 3*k);
        end
        expect_ev(K_GNT, 3, 5, t0 + 11);
        expect_ev(K_DROP, 3, 0, t0 + 14);
        expect_ev(K_GNT, 1, 1, t0 + 18);
        expect_ev(K_DROP, 1, 0, t0 + 20); expect_ev(K_CPL, 1, 0, t0 + 20);
        expect_ev(K_GNT, 1, 20, t0 + 21);
        expect_ev(K_DROP, 1, 0, t0 + 23); expect_ev(K_CPL, 20, 0, t0 + 23);
        wait_until(t0);
        set_req(5, 1, 0);
        wait_until(t0 + 1);
        clear_req();
        for (int k = 0; k < 3; k++) eop_at(5, t0 + 3 + 3*k);
        wait_until(t0 + 13);
        rst = 1;
        wait_until(t0 + 14);
        rst = 0;
        chk_zero = 1;
        wait_until(t0 + 15);
        chk_zero = 0;
        wait_until(t0 + 16);
        set_req(1, 0, 1); set_req(20, 0, 1);
        wait_until(t0 + 17);
        clear_req();
        eop_at(1, t0 + 19);
        eop_at(20, t0 + 22);
        wait_until(t0 + 26);

        done = 1;
    end

endmodule
